// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 5;

  localparam logic [WIDTH-1:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Two's complement negation when neg is set, pass-through otherwise.
  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? (WIDTH'(0) - x) : x;
  endfunction

endpackage

// File: rtl/div_trial_sub.sv
// Combinational trial subtract for one restoring-division step.
// Kept separate so the subtractor can later be replaced by the CLA chain.
// The partial remainder MSB is always 0 before the shift (R < 2^k after k
// steps), so only the low WIDTH-1 bits take part in the shift.
module div_trial_sub
  import div_pkg::*;
(
  input  logic [WIDTH-2:0] rem_low,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_lsb,
  output logic             borrow
);

  logic [WIDTH-1:0] shifted;
  logic [WIDTH:0]   trial;

  // Shift in the next dividend bit, subtract, restore on borrow.
  always_comb begin
    shifted  = {rem_low, q_msb};
    trial    = {1'b0, shifted} - {1'b0, divisor};
    borrow   = trial[WIDTH];
    q_lsb    = ~trial[WIDTH];
    rem_next = trial[WIDTH] ? shifted : trial[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider32.sv
// 32-bit multi-cycle restoring divider, one quotient bit per clock.
// Optional macro SEQ_DIVIDER_SIGNED_EN adds the sgn input for signed DIV/REM.
module seq_divider32
  import div_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef SEQ_DIVIDER_SIGNED_EN
  input  logic             sgn,
`endif
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] wq_q, wq_d;
  logic [WIDTH-1:0] wr_q, wr_d;
  logic [WIDTH-1:0] wd_q, wd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             res_load;
  logic [WIDTH-1:0] res_quo;
  logic [WIDTH-1:0] res_rem;
  logic             res_dz;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  logic [WIDTH-1:0] trial_rem;
  logic             trial_qbit;
  logic             borrow_unused;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic neg_q_q, neg_q_d;
  logic neg_r_q, neg_r_d;
`endif

  div_trial_sub u_trial (
    .rem_low  (wr_q[WIDTH-2:0]),
    .q_msb    (wq_q[WIDTH-1]),
    .divisor  (wd_q),
    .rem_next (trial_rem),
    .q_lsb    (trial_qbit),
    .borrow   (borrow_unused)
  );

  // Operand magnitudes fed to the unsigned core.
  always_comb begin
`ifdef SEQ_DIVIDER_SIGNED_EN
    mag_a = neg_if(dividend, sgn & dividend[WIDTH-1]);
    mag_b = neg_if(divisor,  sgn & divisor[WIDTH-1]);
`else
    mag_a = dividend;
    mag_b = divisor;
`endif
  end

  // Next-state, datapath and result-load logic.
  always_comb begin
    state_d  = state_q;
    wq_d     = wq_q;
    wr_d     = wr_q;
    wd_d     = wd_q;
    cnt_d    = cnt_q;
    res_load = 1'b0;
    res_quo  = quotient;
    res_rem  = remainder;
    res_dz   = div_by_zero;
`ifdef SEQ_DIVIDER_SIGNED_EN
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
`endif

    case (state_q)
      RUN: begin
        wq_d  = {wq_q[WIDTH-2:0], trial_qbit};
        wr_d  = trial_rem;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d  = DONE;
          res_load = 1'b1;
          res_dz   = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
          res_quo  = neg_if(wq_d, neg_q_q);
          res_rem  = neg_if(wr_d, neg_r_q);
`else
          res_quo  = wq_d;
          res_rem  = wr_d;
`endif
        end
      end
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          if (divisor == '0) begin
            state_d  = DONE;
            res_load = 1'b1;
            res_quo  = DIV0_QUOTIENT;
            res_rem  = dividend;
            res_dz   = 1'b1;
          end else begin
            state_d = RUN;
            wq_d    = mag_a;
            wr_d    = '0;
            wd_d    = mag_b;
            cnt_d   = '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_q_d = sgn & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r_d = sgn & dividend[WIDTH-1];
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, working registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wq_q        <= '0;
      wr_q        <= '0;
      wd_q        <= '0;
      cnt_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wq_q    <= wq_d;
      wr_q    <= wr_d;
      wd_q    <= wd_d;
      cnt_q   <= cnt_d;
      busy    <= (state_d == RUN);
      done    <= (state_d == DONE);
      if (res_load) begin
        quotient    <= res_quo;
        remainder   <= res_rem;
        div_by_zero <= res_dz;
      end
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
`endif
    end
  end

endmodule

// File: tb/tb_seq_divider32.sv
// Directed self-checking bench for seq_divider32.
module tb_seq_divider32;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;
`ifdef SEQ_DIVIDER_SIGNED_EN
  logic        sgn;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_divider32 dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
`ifdef SEQ_DIVIDER_SIGNED_EN
    .sgn         (sgn),
`endif
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one start and wait (bounded) for done; report latency and busy cycles.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busy_cycles);
    dividend    = a;
    divisor     = b;
    start       = 1'b1;
    lat         = 0;
    busy_cycles = 0;
    do begin
      step();
      lat++;
      start = 1'b0;
      if (busy) busy_cycles++;
    end while (!done && lat < 100);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    step(); step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (quotient !== 32'h0) begin failures++; $display("FAIL reset_quotient got=%h exp=0", quotient); end
    checks++; if (remainder !== 32'h0) begin failures++; $display("FAIL reset_remainder got=%h exp=0", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin failures++; $display("FAIL reset_dz got=%b exp=0", div_by_zero); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int lat, bc;
    run_div(32'd100, 32'd7, lat, bc);
    checks++; if (lat !== 33) begin failures++; $display("FAIL basic_latency got=%0d exp=33", lat); end
    checks++; if (bc !== 32) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=32", bc); end
    checks++; if (quotient !== 32'd14) begin failures++; $display("FAIL basic_quotient got=%0d exp=14", quotient); end
    checks++; if (remainder !== 32'd2) begin failures++; $display("FAIL basic_remainder got=%0d exp=2", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin failures++; $display("FAIL basic_dz got=%b exp=0", div_by_zero); end
    step();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
    checks++; if (quotient !== 32'd14) begin failures++; $display("FAIL basic_hold got=%0d exp=14", quotient); end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    run_div(32'hFFFF_FFFF, 32'd1, lat, bc);
    checks++; if (lat !== 33) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=33", lat); end
    checks++; if (quotient !== 32'hFFFF_FFFF) begin failures++; $display("FAIL b2b_first_quotient got=%h exp=ffffffff", quotient); end
    checks++; if (remainder !== 32'h0) begin failures++; $display("FAIL b2b_first_remainder got=%h exp=0", remainder); end
    // Start raised while done is high.
    dividend = 32'd10; divisor = 32'd20; start = 1'b1;
    lat = 0;
    do begin
      step();
      lat++;
      start = 1'b0;
    end while (!done && lat < 100);
    checks++; if (lat !== 33) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=33", lat); end
    checks++; if (quotient !== 32'd0) begin failures++; $display("FAIL b2b_second_quotient got=%0d exp=0", quotient); end
    checks++; if (remainder !== 32'd10) begin failures++; $display("FAIL b2b_second_remainder got=%0d exp=10", remainder); end
    step();
  endtask

  task automatic test_div_zero();
    int lat, bc;
    run_div(32'd55, 32'd0, lat, bc);
    checks++; if (lat !== 1) begin failures++; $display("FAIL dz_latency got=%0d exp=1", lat); end
    checks++; if (quotient !== 32'hFFFF_FFFF) begin failures++; $display("FAIL dz_quotient got=%h exp=ffffffff", quotient); end
    checks++; if (remainder !== 32'd55) begin failures++; $display("FAIL dz_remainder got=%0d exp=55", remainder); end
    checks++; if (div_by_zero !== 1'b1) begin failures++; $display("FAIL dz_flag got=%b exp=1", div_by_zero); end
    step();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL dz_done_pulse got=%b exp=0", done); end
    dividend = 32'd9; divisor = 32'd3; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    checks++; if (div_by_zero !== 1'b1) begin failures++; $display("FAIL dz_flag_held got=%b exp=1", div_by_zero); end
    lat = 3;
    while (!done && lat < 100) begin
      step();
      lat++;
    end
    checks++; if (lat !== 33) begin failures++; $display("FAIL dz_next_latency got=%0d exp=33", lat); end
    checks++; if (quotient !== 32'd3) begin failures++; $display("FAIL dz_next_quotient got=%0d exp=3", quotient); end
    checks++; if (remainder !== 32'd0) begin failures++; $display("FAIL dz_next_remainder got=%0d exp=0", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin failures++; $display("FAIL dz_flag_cleared got=%b exp=0", div_by_zero); end
    step();
  endtask

  task automatic test_start_ignored();
    int lat;
    dividend = 32'd1000; divisor = 32'd10; start = 1'b1;
    lat = 0;
    do begin
      step();
      lat++;
      start = 1'b0;
      if (lat == 5) begin
        start = 1'b1; dividend = 32'd77; divisor = 32'd7;
      end
    end while (!done && lat < 100);
    checks++; if (lat !== 33) begin failures++; $display("FAIL ignore_latency got=%0d exp=33", lat); end
    checks++; if (quotient !== 32'd100) begin failures++; $display("FAIL ignore_quotient got=%0d exp=100", quotient); end
    checks++; if (remainder !== 32'd0) begin failures++; $display("FAIL ignore_remainder got=%0d exp=0", remainder); end
    step();
  endtask

  task automatic test_reset_abort();
    int seen;
    dividend = 32'd500; divisor = 32'd3; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 15; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL abort_done got=%b exp=0", done); end
    checks++; if (quotient !== 32'd0) begin failures++; $display("FAIL abort_quotient got=%0d exp=0", quotient); end
    checks++; if (remainder !== 32'd0) begin failures++; $display("FAIL abort_remainder got=%0d exp=0", remainder); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done || busy) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", seen); end
  endtask

  task automatic test_table();
    logic [31:0] ta [8] = '{32'd100, 32'd5, 32'd12345, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1000000, 32'h8000_0000};
    logic [31:0] tb [8] = '{32'd7, 32'd9, 32'd1, 32'hFFFF_FFFF, 32'h8000_0001, 32'd5, 32'd1000, 32'd3};
    logic [31:0] tq [8] = '{32'd14, 32'd0, 32'd12345, 32'd1, 32'd1, 32'd0, 32'd1000, 32'h2AAA_AAAA};
    logic [31:0] tr [8] = '{32'd2, 32'd5, 32'd0, 32'd0, 32'h7FFF_FFFE, 32'd0, 32'd0, 32'd2};
    int lat, bc;
    for (int i = 0; i < 8; i++) begin
      run_div(ta[i], tb[i], lat, bc);
      checks++;
      if (lat !== 33 || quotient !== tq[i] || remainder !== tr[i]) begin
        failures++;
        $display("FAIL table_%0d %h/%h got q=%h r=%h lat=%0d exp q=%h r=%h lat=33",
                 i, ta[i], tb[i], quotient, remainder, lat, tq[i], tr[i]);
      end
      step();
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic [63:0] recon;
    int lat, bc;
    for (int i = 0; i < 200; i++) begin
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (b == 32'd0) b = 32'd1;
      run_div(a, b, lat, bc);
      recon = 64'(quotient) * 64'(b) + 64'(remainder);
      checks++;
      if (lat !== 33 || recon !== 64'(a) || remainder >= b) begin
        failures++;
        $display("FAIL random_%0d %h/%h got q=%h r=%h lat=%0d exp q*d+r==n, r<d, lat=33",
                 i, a, b, quotient, remainder, lat);
      end
    end
    step();
  endtask

`ifdef SEQ_DIVIDER_SIGNED_EN
  task automatic test_signed();
    logic [31:0] sa [4] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FFF7};
    logic [31:0] sb [4] = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] sq [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] sr [4] = '{32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFF7};
    int sl [4] = '{33, 33, 33, 1};
    int lat, bc;
    sgn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_div(sa[i], sb[i], lat, bc);
      checks++;
      if (lat !== sl[i] || quotient !== sq[i] || remainder !== sr[i]) begin
        failures++;
        $display("FAIL signed_%0d %h/%h got q=%h r=%h lat=%0d exp q=%h r=%h lat=%0d",
                 i, sa[i], sb[i], quotient, remainder, lat, sq[i], sr[i], sl[i]);
      end
      step();
    end
    sgn = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
    sgn = 1'b0;
`endif
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_start_ignored();
    test_reset_abort();
    test_table();
    test_random();
`ifdef SEQ_DIVIDER_SIGNED_EN
    test_signed();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
